// File: rtl/vfifo_multi_channel_fifo_pkg.sv
// vfifo_multi_channel_fifo_pkg: shared defaults and size helpers for the multi-channel FIFO
package vfifo_multi_channel_fifo_pkg;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_CH_ADDR_WIDTH = 4;
    localparam int DEF_CH_SEL_WIDTH  = 2;
    localparam int DEF_AFULL_LEVEL   = 12;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction
endpackage

// File: rtl/vfifo_multi_channel_fifo_ram.sv
// vfifo_mc_ram_sdp: simple dual-port RAM with synchronous write and registered, enabled read
module vfifo_mc_ram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // storage array is never reset
    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    // output register holds its value between accepted reads
    always_ff @(posedge clk or negedge rst)
        if (!rst) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/vfifo_multi_channel_fifo.sv
// vfifo_multi_channel_fifo: NR_CH logical FIFOs sharing one RAM, one fixed region per channel
module vfifo_multi_channel_fifo
    import vfifo_multi_channel_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CH_ADDR_WIDTH = DEF_CH_ADDR_WIDTH,
    parameter int CH_SEL_WIDTH  = DEF_CH_SEL_WIDTH,
    parameter int AFULL_LEVEL   = DEF_AFULL_LEVEL,
    localparam int NR_CH        = depth_of(CH_SEL_WIDTH),
    localparam int DEPTH        = depth_of(CH_ADDR_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CH_SEL_WIDTH-1:0]  wr_ch,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [CH_SEL_WIDTH-1:0]  rd_ch,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic [NR_CH-1:0]         full,
    output logic [NR_CH-1:0]         empty,
    output logic [NR_CH-1:0]         almost_full,
    output logic [CH_ADDR_WIDTH:0]   rd_level,
    output logic                     err_ovf,
    output logic                     err_udf
);
    localparam int CW = CH_ADDR_WIDTH + 1;

    logic [NR_CH-1:0][CH_ADDR_WIDTH-1:0] wptr_all, rptr_all;
    logic [NR_CH-1:0][CW-1:0]            cnt_all;
    logic                                wr_acc, rd_acc;

    assign wr_acc   = wr_en & ~full[wr_ch];
    assign rd_acc   = rd_en & ~empty[rd_ch];
    assign rd_level = cnt_all[rd_ch];

    for (genvar i = 0; i < NR_CH; i++) begin : g_ch
        logic [CH_ADDR_WIDTH-1:0] wptr, rptr;
        logic [CW-1:0]            cnt;
        logic                     wi, ri;
        assign wi = wr_acc && (wr_ch == CH_SEL_WIDTH'(i));
        assign ri = rd_acc && (rd_ch == CH_SEL_WIDTH'(i));
        // per-channel pointers wrap naturally; count nets out a same-cycle write and read
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                wptr <= wptr + CH_ADDR_WIDTH'(wi);
                rptr <= rptr + CH_ADDR_WIDTH'(ri);
                cnt  <= cnt + CW'(wi) - CW'(ri);
            end
        assign wptr_all[i]    = wptr;
        assign rptr_all[i]    = rptr;
        assign cnt_all[i]     = cnt;
        assign empty[i]       = cnt == '0;
        assign full[i]        = cnt == CW'(DEPTH);
        assign almost_full[i] = cnt >= CW'(AFULL_LEVEL);
    end

    // read strobe and rejection pulses, all one cycle after the request
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rd_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            err_ovf  <= wr_en & full[wr_ch];
            err_udf  <= rd_en & empty[rd_ch];
        end

    vfifo_mc_ram_sdp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(CH_SEL_WIDTH + CH_ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_acc),
        .wr_addr({wr_ch, wptr_all[wr_ch]}),
        .wr_data(wr_data),
        .rd_en  (rd_acc),
        .rd_addr({rd_ch, rptr_all[rd_ch]}),
        .rd_data(rd_data)
    );
endmodule
